// File: rtl/pwm_pkg.sv
// Shared constants and types for the dual-channel PWM generator.
package pwm_pkg;

    localparam int PWM_PERIOD_DEF = 180;
    localparam int PWM_DEAD_DEF   = 2;
    localparam int DUTY_W         = 8;

    typedef logic [DUTY_W-1:0] duty_t;

    // Anything above the period is stored as a full-period (100%) duty.
    function automatic duty_t clamp_duty(input duty_t d, input duty_t lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/dead_time_gate.sv
// Delays every rising edge of a raw gate signal by DEAD cycles; falling edges pass after one register.
module dead_time_gate #(
    parameter int DEAD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic out
);

    localparam int RUN_W = (DEAD < 1) ? 1 : $clog2(DEAD + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEAD);

    logic [RUN_W-1:0] run;

    // run saturates, so a raw signal held high across period wraps never re-arms the dead-time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= '0;
            out <= 1'b0;
        end else begin
            out <= raw && (run == RUN_MAX);
            if (!raw) begin
                run <= '0;
            end else if (run != RUN_MAX) begin
                run <= run + RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_dual_out.sv
// Complementary high/low PWM pair with double-buffered duties, interlock and dead-time insertion.
module pwm_dual_out
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD_DEF,
    parameter int DEAD   = PWM_DEAD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] duty_h,
    input  logic [7:0] duty_l,
    output logic       pwm_h,
    output logic       pwm_l,
    output logic       period_start,
    output logic       conflict
);

    localparam int PCNT_W = $clog2(PERIOD);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);
    localparam duty_t PERIOD_D = duty_t'(PERIOD);

    logic [PCNT_W-1:0] pcnt;
    duty_t             shadow_h;
    duty_t             shadow_l;
    logic              load;
    logic              both_set;
    logic              raw_h;
    logic              raw_l;

    // While idle the shadows track the inputs, so enabling starts with current duties.
    assign load = !en || (pcnt == PCNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!en || (pcnt == PCNT_LAST)) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_h <= '0;
            shadow_l <= '0;
        end else if (load) begin
            shadow_h <= clamp_duty(duty_h, PERIOD_D);
            shadow_l <= clamp_duty(duty_l, PERIOD_D);
        end
    end

    // High side wins when both channels ask to conduct.
    assign both_set = (shadow_h != '0) && (shadow_l != '0);
    assign raw_h    = en && (duty_t'(pcnt) < shadow_h);
    assign raw_l    = en && (duty_t'(pcnt) < shadow_l) && !both_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
            conflict     <= 1'b0;
        end else begin
            period_start <= en && (pcnt == '0);
            conflict     <= conflict || both_set;
        end
    end

    dead_time_gate #(.DEAD(DEAD)) u_gate_h (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_h),
        .out   (pwm_h)
    );

    dead_time_gate #(.DEAD(DEAD)) u_gate_l (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_l),
        .out   (pwm_l)
    );

endmodule
